switch_controller: RTL and testbench
====================================

SWITCH_CONTROLLER -- requirements
Module: switch_controller

Interface
REQ-001 SHALL have parameter N_BTN, default 4, number of button requesters sharing one light.
REQ-002 SHALL have parameter TIMEOUT, default 1000, auto-off interval in sClk cycles.
REQ-003 SHALL have parameter CNT_W, default $clog2(TIMEOUT+1), timer width.
REQ-004 SHALL have port sClk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port sReset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port sButton  input  N_BTN  raw button levels, one bit per requester.
REQ-007 SHALL have port sLuz  output  1  registered light enable.
REQ-008 SHALL have port sOwner  output  $clog2(N_BTN)  registered index of requester that turned the light on.
REQ-009 SHALL have port sTimer  output  CNT_W  registered remaining cycles before auto-off; 0 when off.

Function
REQ-010 SHALL register sButton twice (btn_q, btn_qq); press[i] = btn_q[i] & ~btn_qq[i].
REQ-011 SHALL implement a two-state FSM: OFF (sLuz=0) and ON (sLuz=1).
REQ-012 OFF -> ON on any press; winner = first pressed index at or after round-robin pointer rr_ptr, wrapping at N_BTN-1 -> 0.
REQ-013 On an OFF->ON grant, sOwner SHALL load the winner, rr_ptr SHALL load winner+1 modulo N_BTN, sTimer SHALL load TIMEOUT.
REQ-014 rr_ptr SHALL change only on an OFF->ON grant.
REQ-015 In ON, press[sOwner] SHALL move to OFF, clear sTimer, keep sOwner.
REQ-016 In ON, a non-owner press without owner press SHALL reload sTimer to TIMEOUT and stay ON.
REQ-017 In ON with no press, sTimer SHALL decrement by 1 per cycle; when sTimer==1 the next edge SHALL move to OFF with sTimer=0.
REQ-018 Simultaneous owner press and non-owner press SHALL give OFF (owner wins).
REQ-019 Non-owner press in the expiry cycle (sTimer==1) SHALL reload TIMEOUT and stay ON (press beats expiry).
REQ-020 Latency: sButton[i] rising before edge k SHALL be reflected in sLuz after edge k+1 (2 cycles).
REQ-021 A held button SHALL generate exactly one press; re-press requires release for at least one sampled cycle.

Reset
REQ-022 sReset high at an edge SHALL force OFF, sLuz=0, sOwner=0, sTimer=0, rr_ptr=0, btn_q=btn_qq=0.
REQ-023 Reset SHALL win over any simultaneous press or expiry; mid-ON reset SHALL turn the light off at that edge.
REQ-024 A button held across reset release SHALL produce a press one cycle after release (btn_qq cleared).

Configuration
REQ-025 Macro SWITCH_AUTO_OFF_EN SHALL compile in the timer (REQ-016, REQ-017, REQ-019).
REQ-026 Without SWITCH_AUTO_OFF_EN: no timer register, sTimer tied to 0, light stays ON until owner press, non-owner presses ignored.

Structure
REQ-027 Shared package switch_pkg SHALL hold the state enum (S_OFF, S_ON) and default constants N_BTN_DEF=4, TIMEOUT_DEF=1000.
REQ-028 Round-robin selection SHALL be a sub-module switch_rr_arbiter (inputs press vector, rr_ptr; outputs grant valid, grant index), purely combinational.
REQ-029 FSM, timer, edge detect and output registers SHALL stay in switch_controller.

Verification
REQ-030 Reset, sButton=4'b0010 for 3 cycles -> sLuz=1 two cycles after rise, sOwner=1, sTimer=1000, rr_ptr=2.
REQ-031 From ON owner=1, press bit1 -> sLuz=0, sTimer=0; press bits 0 and 3 together next (rr_ptr=2) -> sOwner=3.
REQ-032 TIMEOUT=8, press bit0, no further input -> sLuz high exactly 8 cycles then 0; press bit2 at sTimer==1 -> sTimer=8, sLuz stays 1.
REQ-033 ON owner=0, press bits 0 and 2 same cycle -> sLuz=0 (owner wins).
REQ-034 ON with sTimer=5, assert sReset one cycle while button held -> sLuz=0, sOwner=0, sTimer=0; press registered one cycle after reset release.
REQ-035 Build without SWITCH_AUTO_OFF_EN: press bit0, wait 5000 cycles -> sLuz still 1, sTimer=0; press bit1 -> no change; press bit0 -> sLuz=0.

Source files
------------

// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switch_pkg
// Description : Shared types and default constants for the shared-light
//               switch controller.
// Revision    : 1.0 - initial release
// ============================================================================
package switch_pkg;

  typedef enum logic [0:0] {
    S_OFF = 1'b0,
    S_ON  = 1'b1
  } switch_state_t;

  localparam int N_BTN_DEF   = 4;
  localparam int TIMEOUT_DEF = 1000;

  // Width of an index into n requesters; never below one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : switch_pkg
`default_nettype wire

// File: rtl/switch_if.sv
`default_nettype none
// ============================================================================
// Module      : switch_if
// Description : Button inputs and light status outputs of the switch
//               controller. The controller attaches as slave, the button
//               panel / observer as master.
// Revision    : 1.0 - initial release
// ============================================================================
interface switch_if
  import switch_pkg::*;
#(
  parameter int N_BTN   = N_BTN_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = $clog2(TIMEOUT + 1),
  parameter int OWN_W   = idxWidth(N_BTN)
);

  logic [N_BTN-1:0] sButton;
  logic             sLuz;
  logic [OWN_W-1:0] sOwner;
  logic [CNT_W-1:0] sTimer;

  modport master (output sButton, input sLuz, input sOwner, input sTimer);
  modport slave  (input sButton, output sLuz, output sOwner, output sTimer);

endinterface : switch_if
`default_nettype wire

// File: rtl/switch_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : switch_rr_arbiter
// Description : Combinational round-robin pick: first asserted press at or
//               after the pointer, wrapping from N_BTN-1 back to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_rr_arbiter
  import switch_pkg::*;
#(
  parameter int N_BTN = N_BTN_DEF,
  parameter int OWN_W = idxWidth(N_BTN)
) (
  input  logic [N_BTN-1:0] i_press,
  input  logic [OWN_W-1:0] i_rrPtr,
  output logic             o_grantValid,
  output logic [OWN_W-1:0] o_grantIdx
);

  // Scan offsets from the farthest down to zero so the nearest hit wins.
  always_comb begin
    o_grantValid = 1'b0;
    o_grantIdx   = '0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      if (i_press[(int'(i_rrPtr) + k) % N_BTN]) begin
        o_grantValid = 1'b1;
        o_grantIdx   = OWN_W'((int'(i_rrPtr) + k) % N_BTN);
      end
    end
  end

endmodule : switch_rr_arbiter
`default_nettype wire

// File: rtl/switch_controller.sv
`default_nettype none
// ============================================================================
// Module      : switch_controller
// Description : N_BTN buttons share one light. A press while off turns the
//               light on for the round-robin winner; the owner's next press
//               turns it off.
//               Macro SWITCH_AUTO_OFF_EN adds an auto-off timer reloaded by
//               non-owner presses.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_controller
  import switch_pkg::*;
#(
  parameter int N_BTN   = N_BTN_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic     sClk,
  input  logic     sReset,
  switch_if.slave  bus
);

  localparam int c_OWN_W = idxWidth(N_BTN);

  logic [N_BTN-1:0]   r_btnQ;
  logic [N_BTN-1:0]   r_btnQq;
  logic [N_BTN-1:0]   w_press;
  switch_state_t      r_state;
  switch_state_t      w_nextState;
  logic [c_OWN_W-1:0] r_owner;
  logic [c_OWN_W-1:0] w_nextOwner;
  logic [c_OWN_W-1:0] r_rrPtr;
  logic [c_OWN_W-1:0] w_nextRrPtr;
  logic               w_grantValid;
  logic [c_OWN_W-1:0] w_grantIdx;

  // Two-stage input sampling; the second stage feeds rising-edge detection.
  always_ff @(posedge sClk) begin
    if (sReset) begin
      r_btnQ  <= '0;
      r_btnQq <= '0;
    end else begin
      r_btnQ  <= bus.sButton;
      r_btnQq <= r_btnQ;
    end
  end

  assign w_press = r_btnQ & ~r_btnQq;

  switch_rr_arbiter #(
    .N_BTN (N_BTN),
    .OWN_W (c_OWN_W)
  ) u_arb (
    .i_press      (w_press),
    .i_rrPtr      (r_rrPtr),
    .o_grantValid (w_grantValid),
    .o_grantIdx   (w_grantIdx)
  );

`ifdef SWITCH_AUTO_OFF_EN
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_nextTimer;
`endif

  // Next-state logic: grant when off; owner press, refresh or expiry when on.
  always_comb begin
    w_nextState = r_state;
    w_nextOwner = r_owner;
    w_nextRrPtr = r_rrPtr;
`ifdef SWITCH_AUTO_OFF_EN
    w_nextTimer = r_timer;
`endif
    case (r_state)
      S_OFF: begin
        if (w_grantValid) begin
          w_nextState = S_ON;
          w_nextOwner = w_grantIdx;
          w_nextRrPtr = (w_grantIdx == c_OWN_W'(N_BTN - 1)) ? '0 : w_grantIdx + 1'b1;
`ifdef SWITCH_AUTO_OFF_EN
          w_nextTimer = CNT_W'(TIMEOUT);
`endif
        end
      end
      S_ON: begin
        if (w_press[r_owner]) begin
          w_nextState = S_OFF;
`ifdef SWITCH_AUTO_OFF_EN
          w_nextTimer = '0;
`endif
        end
`ifdef SWITCH_AUTO_OFF_EN
        // Any other press counts as activity and beats a same-cycle expiry.
        else if (|w_press) begin
          w_nextTimer = CNT_W'(TIMEOUT);
        end else if (r_timer <= CNT_W'(1)) begin
          w_nextState = S_OFF;
          w_nextTimer = '0;
        end else begin
          w_nextTimer = r_timer - 1'b1;
        end
`endif
      end
      default: w_nextState = S_OFF;
    endcase
  end

  // State, owner and round-robin pointer registers.
  always_ff @(posedge sClk) begin
    if (sReset) begin
      r_state <= S_OFF;
      r_owner <= '0;
      r_rrPtr <= '0;
    end else begin
      r_state <= w_nextState;
      r_owner <= w_nextOwner;
      r_rrPtr <= w_nextRrPtr;
    end
  end

`ifdef SWITCH_AUTO_OFF_EN
  // Remaining on-time counter.
  always_ff @(posedge sClk) begin
    if (sReset) begin
      r_timer <= '0;
    end else begin
      r_timer <= w_nextTimer;
    end
  end

  assign bus.sTimer = r_timer;
`else
  assign bus.sTimer = '0;
`endif

  assign bus.sLuz   = (r_state == S_ON);
  assign bus.sOwner = r_owner;

endmodule : switch_controller
`default_nettype wire

// File: tb/tb_switch_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_controller
// Description : Scoreboard bench for switch_controller (N_BTN=4, TIMEOUT=8).
//               Covers both builds of SWITCH_AUTO_OFF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_controller;

  localparam int TO    = 8;
  localparam int NB    = 4;
  localparam int CW    = $clog2(TO + 1);

  typedef struct {
    string name;
    int    luz;
    int    own;
    int    tim;
  } exp_t;

  logic  sClk = 1'b0;
  logic  sReset = 1'b1;
  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;

  switch_if #(.N_BTN(NB), .TIMEOUT(TO), .CNT_W(CW)) bus ();

  switch_controller #(.N_BTN(NB), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .sClk   (sClk),
    .sReset (sReset),
    .bus    (bus)
  );

  always #5 sClk = ~sClk;

  function automatic int tmr(input int v);
`ifdef SWITCH_AUTO_OFF_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge sClk);
    #1;
  endtask

  task automatic push(input string n, input int l, input int o, input int t);
    exp_t e;
    e.name = n; e.luz = l; e.own = o; e.tim = t;
    q.push_back(e);
  endtask

  task automatic chk(input string n, input string f, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s.%s actual=%0d required=%0d", n, f, act, req);
    end
  endtask

  // Monitor: outputs are stable mid-cycle; check every pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge sClk);
      while (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "sLuz",   int'(bus.sLuz),   e.luz);
        chk(e.name, "sOwner", int'(bus.sOwner), e.own);
        chk(e.name, "sTimer", int'(bus.sTimer), e.tim);
      end
    end
  end

  initial begin
    bus.sButton = '0;
    sReset = 1'b1;
    tick(); tick();
    push("reset", 0, 0, 0);
    sReset = 1'b0;

    // Single press on bit1: latency and grant.
    bus.sButton = 4'b0010;
    tick(); push("lat_k", 0, 0, 0);
    tick(); push("grant1", 1, 1, tmr(TO));
    tick(); push("held1", 1, 1, tmr(TO-1));
    bus.sButton = 4'b0000;
    tick(); push("rel1", 1, 1, tmr(TO-2));

    // Owner press turns off; then 0 and 3 together with pointer at 2.
    bus.sButton = 4'b0010;
    tick(); push("ownpress", 1, 1, tmr(TO-3));
    tick(); push("off1", 0, 1, 0);
    bus.sButton = 4'b0000;
    tick();
    bus.sButton = 4'b1001;
    tick(); push("pend03", 0, 1, 0);
    tick(); push("grant3", 1, 3, tmr(TO));
    bus.sButton = 4'b0000;
    tick(); push("on3", 1, 3, tmr(TO-1));
    bus.sButton = 4'b1000;
    tick();
    tick(); push("off3", 0, 3, 0);
    bus.sButton = 4'b0000;
    tick();

    // Owner 0, then owner and non-owner together: owner wins.
    bus.sButton = 4'b0001;
    tick(); tick(); push("grant0", 1, 0, tmr(TO));
    bus.sButton = 4'b0000;
    tick();
    bus.sButton = 4'b0101;
    tick(); push("both", 1, 0, tmr(TO-2));
    tick(); push("ownwins", 0, 0, 0);
    bus.sButton = 4'b0000;
    tick();

    // Reset mid-on with a button held across release.
    bus.sButton = 4'b0001;
    tick(); tick(); push("grantE", 1, 0, tmr(TO));
    bus.sButton = 4'b0000;
    tick(); tick(); tick(); push("tim5", 1, 0, tmr(5));
    bus.sButton = 4'b0001;
    sReset = 1'b1;
    tick(); push("midreset", 0, 0, 0);
    sReset = 1'b0;
    tick(); push("postrel", 0, 0, 0);
    tick(); push("heldgrant", 1, 0, tmr(TO));
    bus.sButton = 4'b0000;
    tick();

`ifdef SWITCH_AUTO_OFF_EN
    // Turn off, then auto-off after exactly TO cycles.
    bus.sButton = 4'b0001;
    tick(); tick(); push("offD", 0, 0, 0);
    bus.sButton = 4'b0000;
    tick();
    bus.sButton = 4'b0001;
    tick(); tick();
    for (int i = 0; i < TO; i++) begin
      push("expire_cnt", 1, 0, TO - i);
      tick();
    end
    push("expired", 0, 0, 0);
    bus.sButton = 4'b0000;
    tick();
    // Non-owner press in the expiry cycle reloads.
    bus.sButton = 4'b0001;
    tick(); tick(); push("grantD2", 1, 0, TO);
    bus.sButton = 4'b0000;
    for (int i = 0; i < TO - 2; i++) tick();
    push("tim2", 1, 0, 2);
    bus.sButton = 4'b0100;
    tick(); push("tim1", 1, 0, 1);
    tick(); push("reload", 1, 0, TO);
    bus.sButton = 4'b0000;
`else
    // No timer: light stays on, non-owner ignored, owner turns off.
    for (int i = 0; i < 5000; i++) tick();
    push("stayon", 1, 0, 0);
    bus.sButton = 4'b0010;
    tick(); tick(); push("nonown", 1, 0, 0);
    bus.sButton = 4'b0000;
    tick();
    bus.sButton = 4'b0001;
    tick(); tick(); push("ownoff", 0, 0, 0);
    bus.sButton = 4'b0000;
`endif
    tick();

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge sClk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_switch_controller
`default_nettype wire
